// File: rtl/mem_link_host.sv
// mem_link_host: byte-bus memory link host (write/read bursts); `MEM_LINK_PAYLOAD_CHECK_EN rejects reserved payload codes
module mem_link_host (
    input  logic       clk_i,
    input  logic       rst_i,
    inout  wire  [7:0] data_io,
    output logic       mem_oe_o,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_write_i,
    input  logic [2:0] cmd_len_i,
    input  logic [7:0] wr_data_i,
    input  logic       wr_valid_i,
    output logic       wr_ready_o,
    output logic [7:0] rd_data_o,
    output logic       rd_valid_o,
    output logic [2:0] addr_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);
    localparam logic [2:0] IDLE = 3'd0, HDR = 3'd1, WDATA = 3'd2, RPOLL = 3'd3, RTURN = 3'd4, DONE = 3'd5;
    logic [2:0] state, rem, addr_nxt;
    logic       write_q, bad_len, bad_byte, take;
    logic [7:0] drv;
    assign bad_len = cmd_len_i == 3'd0 || cmd_len_i > 3'd5;
`ifdef MEM_LINK_PAYLOAD_CHECK_EN
    assign bad_byte = wr_data_i == 8'h00 || wr_data_i == 8'h01 || wr_data_i == 8'hFF;
`else
    assign bad_byte = 1'b0;
`endif
    assign take        = state == WDATA && wr_valid_i && !bad_byte;
    assign addr_nxt    = addr_o == 3'd4 ? 3'd0 : addr_o + 3'd1;
    assign mem_oe_o    = state == RTURN;
    assign cmd_ready_o = state == IDLE && !rst_i;
    assign wr_ready_o  = state == WDATA;
    assign busy_o      = state != IDLE;
    assign done_o      = state == DONE;
    // 0xFF fills write-side stalls so the memory never sees a stray payload code
    always_comb
        drv = state == HDR   ? (write_q ? 8'hFF : 8'h00) :
              state == WDATA ? (take ? wr_data_i : 8'hFF) :
              state == RPOLL ? 8'h01 : 8'h00;
    assign data_io = mem_oe_o ? 8'bz : drv;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            rem        <= 3'd0;
            write_q    <= 1'b0;
            addr_o     <= 3'd0;
            rd_data_o  <= 8'h00;
            rd_valid_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            rd_valid_o <= 1'b0;
            err_o      <= 1'b0;
            case (state)
                IDLE: if (cmd_valid_i) begin
                    if (bad_len) err_o <= 1'b1;
                    else begin
                        write_q <= cmd_write_i;
                        rem     <= cmd_len_i;
                        state   <= HDR;
                    end
                end
                HDR: state <= write_q ? WDATA : RPOLL;
                WDATA: if (wr_valid_i) begin
                    if (bad_byte) err_o <= 1'b1;
                    else begin
                        rem    <= rem - 3'd1;
                        addr_o <= addr_nxt;
                        if (rem == 3'd1) state <= DONE;
                    end
                end
                RPOLL: state <= RTURN;
                RTURN: begin
                    rd_data_o  <= data_io;
                    rd_valid_o <= 1'b1;
                    rem        <= rem - 3'd1;
                    addr_o     <= addr_nxt;
                    state      <= rem == 3'd1 ? DONE : RPOLL;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_link_host.sv
// tb_mem_link_host: scoreboard bench for mem_link_host with a memory model returning 0xA0+addr
module tb_mem_link_host;
`ifdef MEM_LINK_PAYLOAD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic       clk = 1'b0, rst, cmd_valid, cmd_write, wr_valid;
    logic [2:0] cmd_len;
    logic [7:0] wr_data;
    wire  [7:0] data_io;
    logic       mem_oe_o, cmd_ready_o, wr_ready_o, rd_valid_o, busy_o, done_o, err_o;
    logic [7:0] rd_data_o;
    logic [2:0] addr_o;
    int n_vec = 0, n_bad = 0, n_err = 0, n_done = 0, exp_err = 0, exp_done = 0, exp_addr = 0;
    int cyc = 0, hdr_cyc = 0, last_rd = -1, rd_seen = 0;
    logic [7:0] bus_q[$], rd_q[$];
    logic [7:0] e, prev_bus = 8'h00;
    logic busy_prev = 1'b0;

    mem_link_host dut (
        .clk_i(clk), .rst_i(rst), .data_io(data_io), .mem_oe_o(mem_oe_o),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write), .cmd_len_i(cmd_len),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .addr_o(addr_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    assign data_io = mem_oe_o ? 8'hA0 + {5'd0, addr_o} : 8'bz;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (busy_o && !busy_prev) hdr_cyc = cyc;
        if (busy_o && !mem_oe_o) begin
            e = bus_q.size() > 0 ? bus_q.pop_front() : 8'hEE;
            check("bus", data_io, e);
        end
        if (mem_oe_o) check("oe_after_poll", prev_bus, 8'h01);
        if (rd_valid_o) begin
            e = rd_q.size() > 0 ? rd_q.pop_front() : 8'hEE;
            check("rd_data", rd_data_o, e);
            if (last_rd < hdr_cyc) check("rd_lat", 8'(cyc - hdr_cyc), 8'd3);
            else check("rd_gap", 8'(cyc - last_rd), 8'd2);
            last_rd = cyc;
            rd_seen++;
        end
        if (err_o) n_err++;
        if (done_o) n_done++;
        prev_bus  = data_io;
        busy_prev = busy_o;
    end

    task automatic send_cmd(input logic w, input logic [2:0] len);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_len = len;
        @(negedge clk);
        check("cmd_ready", {7'd0, cmd_ready_o}, 8'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy_o) break;
        end
        check("idle", {7'd0, busy_o}, 8'd0);
    endtask

    task automatic do_write(input int len, input int n, input logic [7:0] b [4], input logic [3:0] gap);
        int rem = len;
        logic bad;
        bus_q.push_back(8'hFF);
        for (int i = 0; i < n && rem > 0; i++) begin
            bad = CHK && (b[i] == 8'h00 || b[i] == 8'h01 || b[i] == 8'hFF);
            if (gap[i]) bus_q.push_back(8'hFF);
            bus_q.push_back(bad ? 8'hFF : b[i]);
            if (bad) exp_err++; else rem--;
        end
        bus_q.push_back(8'h00);
        exp_addr = (exp_addr + len) % 5;
        exp_done++;
        send_cmd(1'b1, 3'(len));
        @(posedge clk); #1;
        rem = len;
        for (int i = 0; i < n && rem > 0; i++) begin
            if (gap[i]) begin
                wr_valid = 1'b0;
                @(posedge clk); #1;
            end
            bad = CHK && (b[i] == 8'h00 || b[i] == 8'h01 || b[i] == 8'hFF);
            wr_valid = 1'b1; wr_data = b[i];
            @(posedge clk); #1;
            if (!bad) rem--;
        end
        wr_valid = 1'b0;
        wait_idle();
        check("wr_addr", {5'd0, addr_o}, 8'(exp_addr));
        check("wr_done", 8'(n_done), 8'(exp_done));
        check("wr_err", 8'(n_err), 8'(exp_err));
    endtask

    task automatic queue_read(input int len);
        bus_q.push_back(8'h00);
        for (int i = 0; i < len; i++) begin
            bus_q.push_back(8'h01);
            rd_q.push_back(8'hA0 + 8'((exp_addr + i) % 5));
        end
        bus_q.push_back(8'h00);
    endtask

    task automatic do_read(input int len);
        queue_read(len);
        exp_addr = (exp_addr + len) % 5;
        exp_done++;
        send_cmd(1'b0, 3'(len));
        wait_idle();
        check("rd_addr", {5'd0, addr_o}, 8'(exp_addr));
        check("rd_done", 8'(n_done), 8'(exp_done));
    endtask

    initial begin
        int base;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_len = 3'd0; wr_valid = 1'b0; wr_data = 8'h00;
        #1;
        check("rst_cmd_ready", {7'd0, cmd_ready_o}, 8'd0);
        check("rst_oe", {7'd0, mem_oe_o}, 8'd0);
        check("rst_bus", data_io, 8'h00);
        check("rst_flags", {2'd0, wr_ready_o, rd_valid_o, busy_o, done_o, err_o, 1'b0}, 8'd0);
        check("rst_addr", {5'd0, addr_o}, 8'd0);
        check("rst_rd_data", rd_data_o, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", {7'd0, cmd_ready_o}, 8'd1);

        do_write(3, 3, '{8'h11, 8'h22, 8'h33, 8'h00}, 4'b0000);
        do_write(2, 2, '{8'h41, 8'h42, 8'h00, 8'h00}, 4'b0010);
        do_read(5);

        for (int k = 0; k < 2; k++) begin
            exp_err++;
            send_cmd(1'b1, k == 0 ? 3'd0 : 3'd6);
            @(negedge clk);
            check("badlen_busy", {7'd0, busy_o}, 8'd0);
            check("badlen_bus", data_io, 8'h00);
            @(negedge clk);
            check("badlen_err", 8'(n_err), 8'(exp_err));
        end

        do_write(2, 3, '{8'hFF, 8'h55, 8'h66, 8'h00}, 4'b0000);

        queue_read(5);
        base = rd_seen;
        send_cmd(1'b0, 3'd5);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (rd_seen >= base + 2) break;
        end
        check("rd_two_seen", 8'(rd_seen - base), 8'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_oe", {7'd0, mem_oe_o}, 8'd0);
        check("mid_rst_busy", {7'd0, busy_o}, 8'd0);
        check("mid_rst_bus", data_io, 8'h00);
        check("mid_rst_addr", {5'd0, addr_o}, 8'd0);
        bus_q.delete();
        rd_q.delete();
        exp_addr = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_no_done", 8'(n_done), 8'(exp_done));

        do_read(2);
        check("err_total", 8'(n_err), 8'(exp_err));
        check("bus_left", 8'(bus_q.size()), 8'd0);
        check("rd_left", 8'(rd_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
